core_out_drain: RTL
===================

# core_out_drain

Downstream drain stage for the accelerator core. It captures each 128-bit output word (8 lanes × 16-bit psum) in the cycle the core asserts `valid` and buffers it in a small FIFO. It then serializes the word into 32-bit beats toward the host/testbench side over a valid/ready handshake. A 4-beat group carries one word.

## Interface
- `col`, 8, number of output lanes per word
- `psum_bw`, 16, bits per lane; lanes are two's-complement signed
- `out_bw`, 32, beat width; `psum_bw*col` must be an integer multiple of `out_bw`, otherwise elaboration fails
- `depth`, 4, FIFO depth in words; power of two, ≥2
- `clk`  input  1  single clock, all state on rising edge
- `reset`  input  1  asynchronous, active-high; clears all state
- `valid`  input  1  core output-word strobe, one word per asserted cycle
- `coreOut`  input  `psum_bw*col`  core output word; lane i = bits `[psum_bw*(i+1)-1 : psum_bw*i]`
- `out_valid`  output  1  beat available
- `out_ready`  input  1  consumer accepts beat
- `out_data`  output  `out_bw`  current beat
- `out_last`  output  1  current beat is the final beat of its word
- `overflow`  output  1  sticky; a word arrived while the FIFO was full and was dropped
- `level`  output  `$clog2(depth+1)`  number of words held, including a partially sent head word
- `words_out`  output  16  count of fully drained words; wraps from 65535 to 0

## Operation
- Push: `valid`=1 and FIFO not full → `coreOut` (after optional ReLU) is written at the write pointer, and the write pointer increments modulo `depth`.
- Pop: the head word is sent as `BEATS = psum_bw*col/out_bw` beats, lowest bits first. Beat k = head bits `[out_bw*(k+1)-1 : out_bw*k]`.
- Beat counter `beat_idx` runs 0..BEATS-1. Handshake fires when `out_valid && out_ready`.
  - On a fire with `beat_idx < BEATS-1`: `beat_idx` increments.
  - On a fire with `beat_idx = BEATS-1`: `beat_idx` returns to 0, the read pointer increments, the word is popped, and `words_out` increments.
- `out_last` = `out_valid && beat_idx == BEATS-1`.
- FSM with two states:
  - `IDLE`: FIFO empty, `out_valid`=0.
  - `SEND`: `out_valid`=1.
  - IDLE→SEND when `level` becomes nonzero.
  - SEND→IDLE on a last-beat fire with `level`=1 and no same-cycle push.
- Boundary cases:
  - Full and `valid`=1 with no same-cycle last-beat pop → word dropped and `overflow` set. `overflow` clears only on reset.
  - Full and `valid`=1 with a same-cycle last-beat pop → the word is accepted, `level` is unchanged, and no overflow is flagged.
  - Empty and `valid`=1 → the word is written; `out_valid` rises the next cycle. There is no combinational bypass.
  - Simultaneous push and non-final-beat fire → push only.
- Consumer rule: while `out_valid`=1 and `out_ready`=0, `out_data`, `out_last` and `beat_idx` hold stable.
- Reset mid-word: the partial word is discarded. Pointers, `beat_idx`, `level`, `overflow` and `words_out` all go to 0.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_last`=0, `overflow`=0, `level`=0, `words_out`=0.
- Latency: a word pushed in cycle N → beat 0 valid in cycle N+1. With `out_ready` held at 1, the word completes in cycle N+BEATS (N+4 at defaults).
- Sustained throughput is one word per BEATS cycles. Core bursts faster than that are absorbed up to `depth` words.
- `out_data` comes from the registered FIFO head through a beat mux. There is no combinational path from `valid`/`coreOut` to any output.
- `out_valid` depends only on registered state. It never depends combinationally on `out_ready`.

## Configuration
- `CORE_OUT_DRAIN_RELU_EN` defined: each lane is clamped to 0 if negative (sign bit set) before it is written to the FIFO. Non-negative lanes pass unchanged.
- `CORE_OUT_DRAIN_RELU_EN` undefined: lanes are stored bit-exact.
- The macro has no effect on timing, latency or `level`.

## Structure
- Shared package holds:
  - localparams `CORE_COL`=8, `CORE_PSUM_BW`=16, `CORE_OUT_BW`=32
  - the derived `BEATS`
  - the drain FSM state encoding (`IDLE`=0, `SEND`=1)
- Sub-module `core_out_fifo`: a synchronous word FIFO with registered storage, wrap-around pointers, a `count` output and full/empty flags.
- The top level holds the ReLU lanes, the beat counter, the FSM, the handshake and the counters.

## Test plan
- Single word, lane i = i+1, `out_ready`=1 → beats 0x00020001, 0x00040003, 0x00060005, 0x00080007 on cycles N+1..N+4. `out_last` on the 4th beat; `words_out`=1.
- Backpressure: hold `out_ready`=0 for 5 cycles mid-word (after beat 1) → `out_data` stays 0x00040003 throughout, then the word resumes with no beat lost or repeated.
- Overflow:
  - 5 consecutive `valid` cycles with `out_ready`=0 → `level`=4 and `overflow`=1, and the 5th word is dropped.
  - Then release `out_ready` → exactly 16 beats come out.
- Full with same-cycle last-beat pop plus push → `level` stays 4 and `overflow` stays 0.
- ReLU: lane 0 = 0xFFF0, lane 1 = 0x0010.
  - With `CORE_OUT_DRAIN_RELU_EN`: beat 0 = 0x00100000.
  - Without it: beat 0 = 0x0010FFF0.
- Assert `reset` after beat 2 of a word → all outputs read 0 in the same cycle, and the next word starts at beat 0.

Source files
------------

// File: rtl/core_out_drain_pkg.sv
// Shared constants and FSM encoding for the core output drain stage.
package core_out_drain_pkg;

    localparam int CORE_COL     = 8;
    localparam int CORE_PSUM_BW = 16;
    localparam int CORE_OUT_BW  = 32;
    localparam int CORE_DEPTH   = 4;
    localparam int BEATS        = (CORE_COL * CORE_PSUM_BW) / CORE_OUT_BW;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } drain_state_e;

endpackage

// File: rtl/core_out_drain_if.sv
// Core-side word strobe plus host-side beat handshake and status for core_out_drain.
interface core_out_drain_if #(
    parameter int COL     = core_out_drain_pkg::CORE_COL,
    parameter int PSUM_BW = core_out_drain_pkg::CORE_PSUM_BW,
    parameter int OUT_BW  = core_out_drain_pkg::CORE_OUT_BW,
    parameter int DEPTH   = core_out_drain_pkg::CORE_DEPTH
);

    logic                       valid;
    logic [PSUM_BW*COL-1:0]     coreOut;
    logic                       out_valid;
    logic                       out_ready;
    logic [OUT_BW-1:0]          out_data;
    logic                       out_last;
    logic                       overflow;
    logic [$clog2(DEPTH+1)-1:0] level;
    logic [15:0]                words_out;

    modport slave (
        input  valid, coreOut, out_ready,
        output out_valid, out_data, out_last, overflow, level, words_out
    );

    modport master (
        output valid, coreOut, out_ready,
        input  out_valid, out_data, out_last, overflow, level, words_out
    );

endinterface

// File: rtl/core_out_drain_fifo.sv
// Synchronous word FIFO with registered storage, wrap-around pointers and occupancy count.
module core_out_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           wdata_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : gBadDepth
        $error("core_out_fifo: DEPTH must be a power of two >= 2");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wrPtr_q;
    logic [PW-1:0]    rdPtr_q;
    logic [CW-1:0]    count_q;

    // Caller guarantees push only when not full or popping in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[wrPtr_q] <= wdata_i;
                wrPtr_q        <= wrPtr_q + PW'(1);
            end
            if (pop_i) rdPtr_q <= rdPtr_q + PW'(1);
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign rdata_o = mem_q[rdPtr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/core_out_drain.sv
// Drain stage: buffers core output words and serializes them into beats over valid/ready.
// Optional feature: define CORE_OUT_DRAIN_RELU_EN to clamp negative lanes to zero on capture.
module core_out_drain
    import core_out_drain_pkg::*;
#(
    parameter int col     = CORE_COL,
    parameter int psum_bw = CORE_PSUM_BW,
    parameter int out_bw  = CORE_OUT_BW,
    parameter int depth   = CORE_DEPTH
) (
    input logic              clk,
    input logic              reset,
    core_out_drain_if.slave  bus
);

    localparam int WORD_BW = psum_bw * col;
    localparam int NBEATS  = WORD_BW / out_bw;
    localparam int BIW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int LW      = $clog2(depth + 1);

    if ((WORD_BW % out_bw) != 0) begin : gBadWidth
        $error("core_out_drain: psum_bw*col must be a multiple of out_bw");
    end

    drain_state_e     state_q, state_d;
    logic [BIW-1:0]   beatIdx_q;
    logic [15:0]      wordsOut_q;
    logic             overflow_q;

    logic [WORD_BW-1:0] captureWord;
    logic [WORD_BW-1:0] headWord;
    logic [LW-1:0]      count;
    logic               full;
    logic               empty;
    logic               outValid;
    logic               fire;
    logic               lastBeat;
    logic               pop;
    logic               push;

    always_comb begin
        captureWord = bus.coreOut;
`ifdef CORE_OUT_DRAIN_RELU_EN
        for (int i = 0; i < col; i++) begin
            if (bus.coreOut[psum_bw*(i+1)-1]) captureWord[psum_bw*i +: psum_bw] = '0;
        end
`endif
    end

    assign outValid = (state_q == SEND);
    assign fire     = outValid && bus.out_ready;
    assign lastBeat = (beatIdx_q == BIW'(NBEATS - 1));
    assign pop      = fire && lastBeat;
    // A full FIFO still accepts a word when the head word leaves in the same cycle.
    assign push     = bus.valid && (!full || pop);

    core_out_fifo #(
        .WIDTH (WORD_BW),
        .DEPTH (depth)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (captureWord),
        .rdata_o (headWord),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (push || !empty) state_d = SEND;
            SEND:    if (pop && (count == LW'(1)) && !push) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            beatIdx_q  <= '0;
            wordsOut_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (fire) beatIdx_q <= lastBeat ? '0 : beatIdx_q + BIW'(1);
            if (pop) wordsOut_q <= wordsOut_q + 16'd1;
            if (bus.valid && full && !pop) overflow_q <= 1'b1;
        end
    end

    assign bus.out_valid = outValid;
    assign bus.out_data  = outValid ? headWord[out_bw*beatIdx_q +: out_bw] : '0;
    assign bus.out_last  = outValid && lastBeat;
    assign bus.overflow  = overflow_q;
    assign bus.level     = count;
    assign bus.words_out = wordsOut_q;

endmodule
